// File: rtl/stall_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: stall
// encodings and FSM state codes.
package stall_ctrl_pkg;

  // Thermometer-coded stall vectors, bit order {inst, id, ex, data}
  localparam logic [3:0] STALL_NONE = 4'b0000;
  localparam logic [3:0] STALL_INST = 4'b1000;
  localparam logic [3:0] STALL_ID   = 4'b1100;
  localparam logic [3:0] STALL_EX   = 4'b1110;
  localparam logic [3:0] STALL_DATA = 4'b1111;

  // Exception sequencing states
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PEND    = 2'b01,
    ST_DISCARD = 2'b10
  } state_e;

endpackage

// File: rtl/stall_ctrl_if.sv
// Bundle of busy/hazard inputs and stall/flush/redirect outputs between
// the pipeline (master) and the stall controller (slave).
interface stall_ctrl_if;
  logic        inst_busy_i;
  logic        data_busy_i;
  logic        ex_busy_i;
  logic        load_use_i;
  logic        exception_i;
  logic [31:0] exc_target_i;
  logic        perf_clr_i;
  logic [3:0]  stall_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        discard_fetch_o;
  logic [31:0] stall_cycles_o;

  modport master (
    output inst_busy_i, data_busy_i, ex_busy_i, load_use_i,
           exception_i, exc_target_i, perf_clr_i,
    input  stall_o, flush_o, redirect_o, redirect_pc_o,
           discard_fetch_o, stall_cycles_o
  );

  modport slave (
    input  inst_busy_i, data_busy_i, ex_busy_i, load_use_i,
           exception_i, exc_target_i, perf_clr_i,
    output stall_o, flush_o, redirect_o, redirect_pc_o,
           discard_fetch_o, stall_cycles_o
  );
endinterface

// File: rtl/stall_ctrl_sat_counter32.sv
// 32-bit saturating event counter with synchronous clear and preload.
// Clear beats load, load beats increment; the count sticks at all-ones.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic [31:0] count
);

  // Count register: clear, preload, or saturating increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller. Produces the priority stall vector,
// sequences exception flushes around outstanding data accesses, drops the
// stale fetch that returns after a redirect, and counts stalled cycles.
module stall_ctrl
  import stall_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  stall_ctrl_if.slave bus
);

  state_e      state;
  state_e      state_next;
  logic [31:0] target_q;
  logic [31:0] target_next;
  logic [3:0]  stall_raw;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] stall_count;

  // Stall vector: the oldest busy stage wins and stalls everything younger
  always_comb begin
    stall_raw = STALL_NONE;
    if (bus.data_busy_i) begin
      stall_raw = STALL_DATA;
    end else if (bus.ex_busy_i) begin
      stall_raw = STALL_EX;
    end else if (bus.load_use_i) begin
      stall_raw = STALL_ID;
    end else if (bus.inst_busy_i || (state == ST_DISCARD)) begin
      stall_raw = STALL_INST;
    end
  end

  // FSM state and latched exception target
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      target_q <= '0;
    end else begin
      state    <= state_next;
      target_q <= target_next;
    end
  end

  // Next state and flush decision; a flush never fires while MEM is busy
  always_comb begin
    state_next  = state;
    target_next = target_q;
    flush       = 1'b0;
    flush_pc    = '0;
    case (state)
      ST_RUN: begin
        if (bus.exception_i) begin
          if (bus.data_busy_i) begin
            target_next = bus.exc_target_i;
            state_next  = ST_PEND;
          end else begin
            flush      = 1'b1;
            flush_pc   = bus.exc_target_i;
            state_next = bus.inst_busy_i ? ST_DISCARD : ST_RUN;
          end
        end
      end
      ST_PEND: begin
        if (!bus.data_busy_i) begin
          flush      = 1'b1;
          flush_pc   = target_q;
          state_next = bus.inst_busy_i ? ST_DISCARD : ST_RUN;
        end
      end
      ST_DISCARD: begin
        if (bus.exception_i) begin
          if (bus.data_busy_i) begin
            target_next = bus.exc_target_i;
            state_next  = ST_PEND;
          end else begin
            flush    = 1'b1;
            flush_pc = bus.exc_target_i;
          end
        end else if (!bus.inst_busy_i) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Stalled-cycle counter; perf clear overrides counting
  sat_counter32 u_stall_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr        (bus.perf_clr_i),
    .inc        (bus.stall_o != STALL_NONE),
    .load       (1'b0),
    .load_value (32'h0000_0000),
    .count      (stall_count)
  );

  // Outputs are forced quiet while reset is held, whatever the inputs do
  assign bus.stall_o         = rst ? stall_raw : STALL_NONE;
  assign bus.flush_o         = rst & flush;
  assign bus.redirect_o      = rst & flush;
  assign bus.redirect_pc_o   = (rst & flush) ? flush_pc : 32'h0000_0000;
  assign bus.discard_fetch_o = (state == ST_DISCARD);
  assign bus.stall_cycles_o  = stall_count;

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: inst_busy_i  in  1  instruction fetch outstanding, no data returned yet.
REQ-004 SHALL have port: data_busy_i  in  1  load/store in MEM outstanding.
REQ-005 SHALL have port: ex_busy_i  in  1  multi-cycle EX operation (mul/div) not done.
REQ-006 SHALL have port: load_use_i  in  1  ID operand depends on a load in EX.
REQ-007 SHALL have port: exception_i  in  1  exception/eret raised by the MEM-stage instruction.
REQ-008 SHALL have port: exc_target_i  in  32  redirect PC belonging to exception_i.
REQ-009 SHALL have port: perf_clr_i  in  1  synchronous clear of the stall counter.
REQ-010 SHALL have port: stall_o  out  4  {inst,id,ex,data} stall vector to all pipeline registers.
REQ-011 SHALL have port: flush_o  out  1  exception flush to all pipeline registers.
REQ-012 SHALL have port: redirect_o  out  1  PC load strobe.
REQ-013 SHALL have port: redirect_pc_o  out  32  PC loaded when redirect_o is high.
REQ-014 SHALL have port: discard_fetch_o  out  1  PC stage SHALL drop the next returning fetch.
REQ-015 SHALL have port: stall_cycles_o  out  32  count of cycles with stall_o != 0.

Function
REQ-016 stall_o SHALL be combinational and thermometer-coded, highest-priority source winning: data_busy_i -> 4'b1111; else ex_busy_i -> 4'b1110; else load_use_i -> 4'b1100; else inst_busy_i or DISCARD state -> 4'b1000; else 4'b0000.
REQ-017 SHALL implement FSM states RUN, PEND, DISCARD; reset state RUN.
REQ-018 RUN: exception_i with data_busy_i low SHALL assert flush_o and redirect_o in the same cycle, with redirect_pc_o = exc_target_i.
REQ-019 In that case, if inst_busy_i is also high, the FSM SHALL go to DISCARD; otherwise it SHALL stay in RUN.
REQ-020 RUN: exception_i with data_busy_i high SHALL latch exc_target_i, assert no flush, and go to PEND.
REQ-021 PEND: flush_o, redirect_o and redirect_pc_o = latched target SHALL assert in the first cycle data_busy_i is low.
REQ-022 PEND SHALL then go to DISCARD if inst_busy_i is high, else to RUN.
REQ-023 In PEND, exception_i SHALL be ignored.
REQ-024 DISCARD: discard_fetch_o SHALL be high and stall_o SHALL be at least 4'b1000.
REQ-025 DISCARD SHALL return to RUN in the cycle after inst_busy_i falls.
REQ-026 In DISCARD, a new exception_i SHALL be handled as in RUN, except that the FSM stays in DISCARD.
REQ-027 flush_o and redirect_o SHALL be single-cycle pulses and never asserted while data_busy_i is high.
REQ-028 redirect_pc_o SHALL be 0 whenever redirect_o is low.
REQ-029 stall_cycles_o SHALL increment by 1 each cycle stall_o != 0 and saturate at 32'hFFFFFFFF.
REQ-030 perf_clr_i SHALL take precedence over increment; a cleared count SHALL read 0 in the next cycle.

Reset
REQ-031 On rst low, the block SHALL immediately (asynchronously) set: FSM = RUN, latched target = 0, stall_cycles_o = 0, discard_fetch_o = 0, flush_o = 0, redirect_o = 0, redirect_pc_o = 0.
REQ-032 stall_o SHALL read 4'b0000 while rst is low, regardless of inputs.
REQ-033 A reset asserted in PEND or DISCARD SHALL discard the pending exception; no flush SHALL occur after release.

Structure
REQ-034 The stall encodings (4'b1111/1110/1100/1000) and FSM state codes SHALL be constants in the shared defines header.
REQ-035 The saturating stall counter SHALL be a sub-module named sat_counter32; everything else SHALL be flat.

Verification
REQ-036 data_busy_i=1 with ex_busy_i=1 and load_use_i=1 -> stall_o=4'b1111; drop data_busy_i -> 4'b1110 in the same cycle.
REQ-037 exception_i=1, exc_target_i=32'hBFC00380, all busy low -> flush_o=redirect_o=1 for exactly one cycle, redirect_pc_o=32'hBFC00380, FSM stays RUN.
REQ-038 exception_i with data_busy_i high for 3 more cycles -> no flush for 3 cycles, then one flush pulse with the latched target; a second exception_i during the wait is ignored.
REQ-039 exception_i with inst_busy_i high for 2 more cycles -> flush that cycle, discard_fetch_o=1 and stall_o=4'b1000 until inst_busy_i falls, RUN one cycle later.
REQ-040 Preload counter to 32'hFFFFFFFE, stall 3 cycles -> reads FFFFFFFF and holds; perf_clr_i during a stall -> 0.
REQ-041 rst pulsed low while in PEND -> all outputs 0 immediately; no flush after release.
